// File: rtl/sumador_pkg.sv
// sumador_pkg: shared FSM state type and operation codes for the serial adder
package sumador_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} estado_t;
  localparam logic OP_SUMA  = 1'b0;
  localparam logic OP_RESTA = 1'b1;
endpackage

// File: rtl/sumador_serie_if.sv
// sumador_serie_if: operand/result valid-ready handshake bundle for sumador_serie
interface sumador_serie_if #(parameter int N = 32);
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] A, B, S;
  logic         Cin, OP, Cout, V, Z;
  modport master (output in_valid, A, B, Cin, OP, out_ready,
                  input  in_ready, out_valid, S, Cout, V, Z);
  modport slave  (input  in_valid, A, B, Cin, OP, out_ready,
                  output in_ready, out_valid, S, Cout, V, Z);
endinterface

// File: rtl/sumador_tramo.sv
// sumador_tramo: combinational M-bit slice adder with carry in/out
module sumador_tramo #(parameter int M = 8) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         ci,
  output logic [M-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (M+1)'(ci);
endmodule

// File: rtl/sumador_serie.sv
// sumador_serie: multi-cycle add/subtract over M-bit slices, LSB slice first.
// Define SUMADOR_SERIE_SAT_EN to saturate S on two's-complement overflow.
module sumador_serie import sumador_pkg::*; #(
  parameter int N = 32,
  parameter int M = 8
) (
  input logic            clk,
  input logic            rst_n,
  sumador_serie_if.slave bus
);
  localparam int K  = N / M;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  if (M < 1 || N % M != 0) begin : g_chk
    $error("sumador_serie: N must be a positive multiple of M");
  end
  estado_t       state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, s_q, s_d, s_w, s_f;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d, cout_q, cout_d, v_q, v_d, z_q, z_d;
  logic          v_w, last, sl_co;
  logic [M-1:0]  sl_s;
  sumador_tramo #(.M(M)) u_tramo (
    .a (a_q[cnt_q*M +: M]),
    .b (b_q[cnt_q*M +: M]),
    .ci(c_q),
    .s (sl_s),
    .co(sl_co)
  );
  assign last = cnt_q == CW'(K - 1);
  // Full-width view of S with the current slice merged; V/Z use it on the last slice
  always_comb begin
    s_w = s_q;
    s_w[cnt_q*M +: M] = sl_s;
    v_w = (a_q[N-1] == b_q[N-1]) && (s_w[N-1] != a_q[N-1]);
`ifdef SUMADOR_SERIE_SAT_EN
    s_f = v_w ? {a_q[N-1], {(N-1){~a_q[N-1]}}} : s_w;
`else
    s_f = s_w;
`endif
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = CALC;
      a_d     = bus.A;
      b_d     = bus.B ^ {N{bus.OP == OP_RESTA}};
      c_d     = bus.Cin ^ bus.OP;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      c_d   = sl_co;
      cnt_d = cnt_q + 1'b1;
      s_d   = last ? s_f : s_w;
      if (last) begin
        state_d = DONE;
        cout_d  = sl_co;
        v_d     = v_w;
        z_d     = s_f == '0;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
endmodule

// File: tb/tb_sumador_serie.sv
// tb_sumador_serie: directed vectors on N=8/M=4 plus random ops on N=32 with K=4 and K=1
module tb_sumador_serie;
  import sumador_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
`ifdef SUMADOR_SERIE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  sumador_serie_if #(.N(8))  b8();
  sumador_serie_if #(.N(32)) b4();
  sumador_serie_if #(.N(32)) b1();
  sumador_serie #(.N(8),  .M(4))  dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  sumador_serie #(.N(32), .M(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  sumador_serie #(.N(32), .M(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] a, b;
    logic       cin, op;
    logic [7:0] s;
    logic       cout, v, z;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic op,
                      output logic [10:0] res, output int lat);
    @(negedge clk);
    b8.A = a; b8.B = b; b8.Cin = cin; b8.OP = op; b8.in_valid = 1'b1;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {b8.S, b8.Cout, b8.V, b8.Z};
  endtask
  task automatic release8;
    @(negedge clk) b8.out_ready = 1'b1;
    @(posedge clk);
    #1 b8.out_ready = 1'b0;
  endtask
  function automatic logic [34:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic op);
    logic [32:0] u;
    longint      sg;
    logic [31:0] s;
    logic        co, v;
    if (op == OP_SUMA) begin
      u  = {1'b0, a} + {1'b0, b} + 33'(cin);
      co = u[32];
      sg = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      u  = {1'b0, a} - {1'b0, b} - 33'(cin);
      co = ~u[32];
      sg = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    s = u[31:0];
    v = sg > MAXV || sg < MINV;
    if (SAT && v) s = sg > 0 ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {s, co, v, s == 32'h0};
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [10:0] res;
    logic [7:0]  es;
    logic        ez;
    int          lat;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.A = '0; b8.B = '0; b8.Cin = 1'b0; b8.OP = 1'b0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.A = '0; b4.B = '0; b4.Cin = 1'b0; b4.OP = 1'b0;
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.A = '0; b1.B = '0; b1.Cin = 1'b0; b1.OP = 1'b0;
    #1 chk("reset_state", {b8.in_ready, b8.out_valid, b8.S, b8.Cout, b8.V, b8.Z}, {2'b10, 8'h00, 3'b000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tv[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tv[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0};
    tv[6] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0};
    tv[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tv[8] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      es = tv[i].s;
      ez = tv[i].z;
      if (SAT && tv[i].v) begin
        es = tv[i].a[7] ? 8'h80 : 8'h7F;
        ez = 1'b0;
      end
      run8(tv[i].a, tv[i].b, tv[i].cin, tv[i].op, res, lat);
      chk($sformatf("vec%0d", i), 64'(res), 64'({es, tv[i].cout, tv[i].v, ez}));
      chk($sformatf("lat%0d", i), 64'(lat), 64'd2);
      release8;
      chk($sformatf("idle%0d", i), {b8.in_ready, b8.out_valid}, 2'b10);
    end
    // Back-pressure: result held, new operands ignored
    run8(8'h7F, 8'h01, 1'b0, 1'b0, res, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b8.A = 8'h11; b8.B = 8'h22; b8.in_valid = 1'b1;
      chk($sformatf("hold%0d", i), {b8.out_valid, b8.in_ready, b8.S, b8.Cout, b8.V, b8.Z}, {2'b10, res});
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1 b8.out_ready = 1'b0;
    chk("hold_release", {b8.out_valid, b8.in_ready, b8.S}, {2'b01, res[10:3]});
    repeat (3) @(negedge clk);
    chk("hold_no_start", {b8.out_valid, b8.in_ready}, 2'b01);
    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    b8.A = 8'h33; b8.B = 8'h44; b8.Cin = 1'b0; b8.OP = 1'b0; b8.in_valid = 1'b1;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {b8.in_ready, b8.out_valid, b8.S, b8.Cout, b8.V, b8.Z}, {2'b10, 8'h00, 3'b000});
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_pulse", b8.out_valid, 1'b0);
    run8(8'h01, 8'h02, 1'b0, 1'b0, res, lat);
    chk("after_rst", 64'(res), 64'({8'h03, 3'b000}));
    chk("after_rst_lat", 64'(lat), 64'd2);
    release8;
    // N=32 with K=4 and K=1 side by side against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a, b;
      logic        cin, op;
      logic [34:0] exp, r4, r1;
      int          l4, l1;
      a = $urandom; b = $urandom;
      if (n % 8 == 0) b = a;
      if (n % 8 == 1) a = 32'h7FFF_FFFF;
      cin = 1'($urandom_range(0, 1));
      op  = 1'($urandom_range(0, 1));
      exp = ref32(a, b, cin, op);
      @(negedge clk);
      b4.A = a; b4.B = b; b4.Cin = cin; b4.OP = op; b4.in_valid = 1'b1;
      b1.A = a; b1.B = b; b1.Cin = cin; b1.OP = op; b1.in_valid = 1'b1;
      @(posedge clk);
      #1 b4.in_valid = 1'b0;
      b1.in_valid = 1'b0;
      l4 = 0; l1 = 0; r4 = '0; r1 = '0;
      for (int c = 1; c <= 10 && (l4 == 0 || l1 == 0); c++) begin
        @(posedge clk);
        #1;
        if (l4 == 0 && b4.out_valid) begin l4 = c; r4 = {b4.S, b4.Cout, b4.V, b4.Z}; end
        if (l1 == 0 && b1.out_valid) begin l1 = c; r1 = {b1.S, b1.Cout, b1.V, b1.Z}; end
      end
      chk($sformatf("k4_res%0d", n), 64'(r4), 64'(exp));
      chk($sformatf("k4_lat%0d", n), 64'(l4), 64'd4);
      chk($sformatf("k1_res%0d", n), 64'(r1), 64'(exp));
      chk($sformatf("k1_lat%0d", n), 64'(l1), 64'd1);
      @(negedge clk);
      b4.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      @(posedge clk);
      #1 b4.out_ready = 1'b0;
      b1.out_ready = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
